// File: rtl/core_frame_ctrl.sv
// Byte-stream front end for crc_sort_core: packs 16 input bytes into one word,
// launches the core, waits for done with a timeout and streams the result back.
module core_frame_ctrl #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic [2:0]   in_fn_sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         core_en,
  output logic         core_start,
  output logic [2:0]   core_fn_sel,
  output logic [127:0] core_data_in,
  input  logic [127:0] core_data_out,
  input  logic         core_done,
  output logic         core_clr,
  output logic         err,
  output logic         busy
);

  // state  | meaning
  // LOAD   | accepting input bytes into the assembly buffer
  // LAUNCH | one-cycle core start
  // WAIT   | core running, timer counting toward TIMEOUT
  // SEND   | streaming the captured result out
  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_SEND   = 2'd3;

  localparam logic [2:0] FN_CRC  = 3'b011;
  localparam logic [2:0] FN_SORT = 3'b100;
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  logic [1:0]   r_state;
  logic [3:0]   r_byte_cnt;
  logic [7:0]   r_timer;
  logic [3:0]   r_out_cnt;
  logic [127:0] r_buf;
  logic [127:0] r_result;
  logic [2:0]   r_fn;
  logic         r_err_code;

  logic         w_fn_ok;
  logic         w_is_sort;
  logic         w_timeout;
  logic         w_out_last;
  logic [127:0] w_shifted;

  assign w_fn_ok    = (r_fn == FN_CRC) || (r_fn == FN_SORT);
  assign w_is_sort  = (r_fn == FN_SORT);
  // done wins over an expiring timer in the same cycle
  assign w_timeout  = (r_state == S_WAIT) && !core_done && (r_timer == TIMER_LAST);
  assign w_out_last = w_is_sort ? (r_out_cnt == 4'd15) : 1'b1;
  assign w_shifted  = r_result << {r_out_cnt, 3'b000};

  assign in_ready     = (r_state == S_LOAD);
  assign out_valid    = (r_state == S_SEND);
  assign core_en      = (r_state == S_LAUNCH) || (r_state == S_WAIT);
  assign core_start   = (r_state == S_LAUNCH);
  assign core_fn_sel  = r_fn;
  assign core_data_in = r_buf;
  assign core_clr     = w_timeout;
  assign err          = r_err_code || w_timeout;
  assign busy         = (r_state != S_LOAD) || (r_byte_cnt != 4'd0);
  assign out_data     = (r_state != S_SEND) ? 8'h00 :
                        (w_is_sort ? w_shifted[127:120] : r_result[7:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_LOAD;
      r_byte_cnt <= 4'd0;
      r_timer    <= 8'd0;
      r_out_cnt  <= 4'd0;
      r_buf      <= '0;
      r_result   <= '0;
      r_fn       <= 3'b000;
      r_err_code <= 1'b0;
    end else begin
      r_err_code <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            r_buf      <= {r_buf[119:0], in_data};
            r_byte_cnt <= r_byte_cnt + 4'd1;
            if (r_byte_cnt == 4'd0) r_fn <= in_fn_sel;
            if (r_byte_cnt == 4'd15) begin
              if (w_fn_ok) r_state <= S_LAUNCH;
              else         r_err_code <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          r_timer <= 8'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            r_result  <= core_data_out;
            r_out_cnt <= 4'd0;
            r_state   <= S_SEND;
          end else if (r_timer == TIMER_LAST) begin
            r_state <= S_LOAD;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            r_out_cnt <= r_out_cnt + 4'd1;
            if (w_out_last) r_state <= S_LOAD;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule
